// File: rtl/mer_calc_pkg.sv
// Shared types and constants for the MER dB calculator: FSM states, log2 fraction table,
// dB scaling and saturation constants.
package mer_calc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLogErr,
        StLogPwr,
        StScale,
        StOut
    } state_e;

    // log2(1 + i/16) in Q0.8
    localparam logic [7:0] LOG2_LUT [16] = '{
        8'd0,   8'd22,  8'd44,  8'd63,  8'd82,  8'd100, 8'd118, 8'd134,
        8'd150, 8'd165, 8'd179, 8'd193, 8'd207, 8'd220, 8'd232, 8'd244
    };

    localparam int          DB_PER_OCT = 771;  // 10*log10(2) in Q2.8
    localparam int          ROUND      = 512;
    localparam logic [15:0] SAT_MAX    = 16'h7FFF;
    localparam logic [15:0] SAT_MIN    = 16'h8000;

endpackage

// File: rtl/mer_db_calc_log2.sv
// Sequential fixed-latency log2: 39 normalise cycles then one result cycle, giving
// log2(operand) - shift as signed Q7.8.
module log2_seq
    import mer_calc_pkg::*;
#(
    parameter int unsigned W = 39
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] operand,
    input  logic [5:0]   shift,
    output logic         done,
    output logic         zero,
    output logic [15:0]  result
);

    localparam logic [5:0] LAST = 6'(W);

    logic [W-1:0] val_q, val_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [5:0]   it_q, it_d;
    logic         zero_q, zero_d;
    logic         run_q, run_d;
    logic [7:0]   int_part;

    always_comb begin
        val_d  = val_q;
        cnt_d  = cnt_q;
        it_d   = it_q;
        zero_d = zero_q;
        run_d  = run_q;
        if (start) begin
            val_d  = operand;
            cnt_d  = '0;
            it_d   = '0;
            zero_d = (operand == '0);
            run_d  = 1'b1;
        end else if (run_q) begin
            if (it_q == LAST) begin
                run_d = 1'b0;
            end else begin
                it_d = it_q + 6'd1;
                // Iteration count is data-independent; a set MSB simply stops the shifting.
                if (!val_q[W-1]) begin
                    val_d = val_q << 1;
                    cnt_d = cnt_q + 6'd1;
                end
            end
        end
    end

    assign done     = run_q && (it_q == LAST);
    assign zero     = zero_q;
    assign int_part = 8'(W - 1) - {2'b00, cnt_q} - {2'b00, shift};
    assign result   = {int_part, LOG2_LUT[val_q[W-2 -: 4]]};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            val_q  <= '0;
            cnt_q  <= '0;
            it_q   <= '0;
            zero_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            it_q   <= it_d;
            zero_q <= zero_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/mer_db_calc.sv
// MER calculator: on each accumulator dump computes 10*log10(P/E) in Q9.6 dB using one
// time-shared sequential log2 unit; result appears 82 cycles after the dump edge.
module mer_db_calc
    import mer_calc_pkg::*;
#(
    parameter int unsigned ERR_W     = 39,
    parameter int unsigned PWR_W     = 18,
    parameter int unsigned ERR_SHIFT = 34,
    parameter int unsigned PWR_SHIFT = 17
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             dump,
    input  logic [ERR_W-1:0] sq_err_acc,
    input  logic [PWR_W-1:0] map_power,
    output logic [15:0]      mer_db,
    output logic             mer_valid,
    output logic             busy,
    output logic             err_zero,
    output logic             pwr_zero,
    output logic             overrun
);

    state_e             state_q, state_d;
    logic               dump_q;
    logic [PWR_W-1:0]   pwr_q, pwr_d;
    logic [15:0]        log_e_q, log_e_d;
    logic signed [15:0] diff_q, diff_d;
    logic               zero_e_q, zero_e_d;
    logic               zero_p_q, zero_p_d;
    logic [15:0]        mer_db_q, mer_db_d;
    logic               mer_valid_q, mer_valid_d;
    logic               err_zero_q, err_zero_d;
    logic               pwr_zero_q, pwr_zero_d;
    logic               overrun_q, overrun_d;

    logic               start;
    logic               log_start, log_done, log_zero;
    logic [ERR_W-1:0]   log_op;
    logic [5:0]         log_shift;
    logic [15:0]        log_res;
    logic signed [31:0] product, rounded;

    assign start = dump & ~dump_q;

    log2_seq #(
        .W (ERR_W)
    ) u_log2 (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (log_start),
        .operand  (log_op),
        .shift    (log_shift),
        .done     (log_done),
        .zero     (log_zero),
        .result   (log_res)
    );

    assign product = 32'(diff_q) * 32'(DB_PER_OCT);
    assign rounded = (product + 32'(ROUND)) >>> 10;

    always_comb begin
        state_d     = state_q;
        pwr_d       = pwr_q;
        log_e_d     = log_e_q;
        diff_d      = diff_q;
        zero_e_d    = zero_e_q;
        zero_p_d    = zero_p_q;
        mer_db_d    = mer_db_q;
        mer_valid_d = 1'b0;
        err_zero_d  = err_zero_q;
        pwr_zero_d  = pwr_zero_q;
        overrun_d   = overrun_q;
        log_start   = 1'b0;
        log_op      = '0;
        log_shift   = '0;

        if (start && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // The log unit's operand register doubles as the capture of sq_err_acc.
                if (start) begin
                    log_start = 1'b1;
                    log_op    = sq_err_acc;
                    log_shift = 6'(ERR_SHIFT);
                    pwr_d     = map_power;
                    state_d   = StLogErr;
                end
            end
            StLogErr: begin
                if (log_done) begin
                    log_e_d   = log_res;
                    zero_e_d  = log_zero;
                    log_start = 1'b1;
                    log_op    = ERR_W'(pwr_q);
                    log_shift = 6'(PWR_SHIFT);
                    state_d   = StLogPwr;
                end
            end
            StLogPwr: begin
                if (log_done) begin
                    diff_d   = $signed(log_res) - $signed(log_e_q);
                    zero_p_d = log_zero;
                    state_d  = StScale;
                end
            end
            StScale: begin
                mer_valid_d = 1'b1;
                err_zero_d  = 1'b0;
                pwr_zero_d  = 1'b0;
                if (zero_e_q) begin
                    mer_db_d   = SAT_MAX;
                    err_zero_d = 1'b1;
                end else if (zero_p_q) begin
                    mer_db_d   = SAT_MIN;
                    pwr_zero_d = 1'b1;
                end else if (rounded > 32'sd32767) begin
                    mer_db_d = SAT_MAX;
                end else if (rounded < -32'sd32768) begin
                    mer_db_d = SAT_MIN;
                end else begin
                    mer_db_d = rounded[15:0];
                end
                state_d = StOut;
            end
            StOut: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StIdle;
            dump_q      <= 1'b0;
            pwr_q       <= '0;
            log_e_q     <= '0;
            diff_q      <= '0;
            zero_e_q    <= 1'b0;
            zero_p_q    <= 1'b0;
            mer_db_q    <= '0;
            mer_valid_q <= 1'b0;
            err_zero_q  <= 1'b0;
            pwr_zero_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dump_q      <= dump;
            pwr_q       <= pwr_d;
            log_e_q     <= log_e_d;
            diff_q      <= diff_d;
            zero_e_q    <= zero_e_d;
            zero_p_q    <= zero_p_d;
            mer_db_q    <= mer_db_d;
            mer_valid_q <= mer_valid_d;
            err_zero_q  <= err_zero_d;
            pwr_zero_q  <= pwr_zero_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mer_db    = mer_db_q;
    assign mer_valid = mer_valid_q;
    assign busy      = (state_q != StIdle);
    assign err_zero  = err_zero_q;
    assign pwr_zero  = pwr_zero_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mer_db_calc.sv
// Self-checking bench for mer_db_calc: directed and random dumps against an arithmetic
// MER model, plus overrun and mid-computation reset scenarios.
module tb_mer_db_calc;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        dump;
    logic [38:0] sq_err_acc;
    logic [17:0] map_power;
    logic [15:0] mer_db;
    logic        mer_valid, busy, err_zero, pwr_zero, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int lut [16] = '{0, 22, 44, 63, 82, 100, 118, 134, 150, 165, 179, 193, 207, 220, 232, 244};

    always #10 CLOCK_50 = ~CLOCK_50;

    mer_db_calc dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .dump       (dump),
        .sq_err_acc (sq_err_acc),
        .map_power  (map_power),
        .mer_db     (mer_db),
        .mer_valid  (mer_valid),
        .busy       (busy),
        .err_zero   (err_zero),
        .pwr_zero   (pwr_zero),
        .overrun    (overrun)
    );

    // log2(x) - sh in Q.8, truncating to the 4 bits below the leading one.
    function automatic longint ref_log2(input longint x, input longint sh);
        int msb;
        int idx;
        msb = 0;
        for (int b = 0; b < 39; b++) if (x[b]) msb = b;
        if (msb >= 4) idx = int'((x >> (msb - 4)) & 15);
        else          idx = int'((x << (4 - msb)) & 15);
        return (longint'(msb) - sh) * 256 + longint'(lut[idx]);
    endfunction

    function automatic logic [15:0] ref_db(input logic [38:0] e, input logic [17:0] p);
        longint d, r;
        logic [63:0] rv;
        if (e == 0) return 16'h7FFF;
        if (p == 0) return 16'h8000;
        d  = ref_log2(longint'(p), 17) - ref_log2(longint'(e), 34);
        r  = (d * 771 + 512) >>> 10;
        if (r > 32767)  return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        rv = r;
        return rv[15:0];
    endfunction

    // Drives one dump edge (2 cycles wide) and checks the single resulting update.
    // edge2: cycle of an extra dump edge (0 = none); rst_at: cycle of a reset pulse (0 = none).
    task automatic run_calc(input logic [38:0] e, input logic [17:0] p, input int edge2,
                            input int rst_at, input logic exp_ovr);
        logic [15:0] exp_db;
        logic [15:0] got_db;
        logic        got_ez, got_pz;
        int          lat, nvalid;
        exp_db = ref_db(e, p);
        lat    = -1;
        nvalid = 0;
        got_db = '0;
        got_ez = 1'b0;
        got_pz = 1'b0;
        @(negedge CLOCK_50);
        sq_err_acc = e;
        map_power  = p;
        dump       = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            @(negedge CLOCK_50);
            if (i == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_after_start: got %b want 1", busy);
                end
                // Change the inputs so a missing capture would be visible.
                sq_err_acc = {7'($urandom), $urandom};
                map_power  = 18'($urandom);
            end
            if (i == 2) dump = 1'b0;
            if (edge2 != 0 && i == edge2) dump = 1'b1;
            if (edge2 != 0 && i == edge2 + 2) dump = 1'b0;
            if (rst_at != 0 && i == rst_at) reset = 1'b1;
            if (rst_at != 0 && i == rst_at + 1) begin
                reset = 1'b0;
                n_checks++;
                if ({mer_db, mer_valid, busy, err_zero, pwr_zero, overrun} !== 21'd0) begin
                    n_fail++;
                    $display("FAIL reset_mid: got db=%h v=%b busy=%b ez=%b pz=%b ovr=%b want all 0",
                             mer_db, mer_valid, busy, err_zero, pwr_zero, overrun);
                end
            end
            if (mer_valid === 1'b1) begin
                nvalid++;
                if (lat < 0) begin
                    lat    = i;
                    got_db = mer_db;
                    got_ez = err_zero;
                    got_pz = pwr_zero;
                end
            end
            if (rst_at == 0 && i == 83) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_after_out: got %b want 0", busy);
                end
            end
        end
        if (rst_at != 0) begin
            n_checks++;
            if (nvalid != 0) begin
                n_fail++;
                $display("FAIL valid_after_reset: got %0d pulses want 0", nvalid);
            end
        end else begin
            n_checks++;
            if (nvalid != 1 || lat != 82) begin
                n_fail++;
                $display("FAIL valid_timing: got %0d pulses latency %0d want 1 pulse latency 82",
                         nvalid, lat);
            end
            n_checks++;
            if (got_db !== exp_db) begin
                n_fail++;
                $display("FAIL mer_db e=%h p=%h: got %h want %h", e, p, got_db, exp_db);
            end
            n_checks++;
            if (got_ez !== (e == 0) || got_pz !== (e != 0 && p == 0)) begin
                n_fail++;
                $display("FAIL zero_flags e=%h p=%h: got ez=%b pz=%b want ez=%b pz=%b",
                         e, p, got_ez, got_pz, (e == 0), (e != 0 && p == 0));
            end
            n_checks++;
            if (mer_db !== exp_db) begin
                n_fail++;
                $display("FAIL mer_db_hold: got %h want %h", mer_db, exp_db);
            end
        end
        n_checks++;
        if (overrun !== exp_ovr) begin
            n_fail++;
            $display("FAIL overrun: got %b want %b", overrun, exp_ovr);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        dump  = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        sq_err_acc = '0;
        map_power  = '0;
        apply_reset();
        @(negedge CLOCK_50);
        n_checks++;
        if ({mer_db, mer_valid, busy, err_zero, pwr_zero, overrun} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got db=%h v=%b busy=%b ez=%b pz=%b ovr=%b want all 0",
                     mer_db, mer_valid, busy, err_zero, pwr_zero, overrun);
        end
    endtask

    task automatic test_directed();
        run_calc(39'd1 << 24, 18'd1 << 17, 0, 0, 1'b0);
        n_checks++;
        if (mer_db !== 16'h0788) begin
            n_fail++;
            $display("FAIL mer_30db: got %h want 0788", mer_db);
        end
        run_calc(39'd1 << 34, 18'd1 << 17, 0, 0, 1'b0);
        run_calc(39'd0, 18'd1 << 17, 0, 0, 1'b0);
        run_calc(39'd1 << 24, 18'd0, 0, 0, 1'b0);
        run_calc(39'd0, 18'd0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [38:0] e;
        logic [17:0] p;
        for (int n = 0; n < 10; n++) begin
            e = {7'($urandom), $urandom} >> $urandom_range(38, 0);
            p = 18'($urandom) >> $urandom_range(17, 0);
            run_calc(e, p, 0, 0, 1'b0);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        run_calc(39'd3 << 20, 18'd5 << 14, 20, 0, 1'b1);
        run_calc(39'd1 << 24, 18'd1 << 17, 0, 0, 1'b1);
        apply_reset();
        run_calc(39'd7 << 30, 18'd9 << 12, 82, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        run_calc(39'd1 << 24, 18'd1 << 17, 0, 50, 1'b0);
        run_calc(39'd11 << 25, 18'd3 << 15, 0, 0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        dump       = 1'b0;
        sq_err_acc = '0;
        map_power  = '0;
        test_reset();
        test_directed();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
